// File: rtl/alu_core.sv
// alu_core: 8-bit ALU with a fast single-cycle path and a multi-cycle path behind a valid/ready handshake.
// Build option: define ALU_MUL_EN to include the iterative shift-add multiplier for opcode 111.
module alu_core #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    input  logic [2:0]        opcode,
    input  logic              single_cycle_mode,
    output logic              o_valid,
    output logic              o_busy,
    output logic              o_error,
    output logic [DATA_W-1:0] result,
    output logic              carry_out,
    output logic              zero_flag,
    output logic              overflow_flag
);
    localparam int SH_W  = $clog2(DATA_W);
    localparam int CNT_W = $clog2(DATA_W);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    localparam logic [CNT_W-1:0] CNT_ALU = CNT_W'(2);

    // Returns {result, carry, overflow} for every non-multiply opcode.
    function automatic logic [DATA_W+1:0] alu_eval(input logic [DATA_W-1:0] a,
                                                   input logic [DATA_W-1:0] b,
                                                   input logic [2:0]        op);
        logic        [DATA_W:0]     uwide;
        logic signed [DATA_W:0]     swide;
        logic        [2*DATA_W-1:0] shw;
        logic        [DATA_W-1:0]   res;
        logic        [SH_W-1:0]     sh;
        logic                       cy;
        logic                       ov;
        uwide = '0;
        swide = '0;
        shw   = '0;
        res   = '0;
        cy    = 1'b0;
        ov    = 1'b0;
        sh    = b[SH_W-1:0];
        case (op)
            OP_ADD: begin
                uwide = {1'b0, a} + {1'b0, b};
                swide = $signed({a[DATA_W-1], a}) + $signed({b[DATA_W-1], b});
                res   = uwide[DATA_W-1:0];
                cy    = uwide[DATA_W];
                ov    = swide[DATA_W] ^ swide[DATA_W-1];
            end
            OP_SUB: begin
                uwide = {1'b0, a} - {1'b0, b};
                swide = $signed({a[DATA_W-1], a}) - $signed({b[DATA_W-1], b});
                res   = uwide[DATA_W-1:0];
                cy    = uwide[DATA_W];
                ov    = swide[DATA_W] ^ swide[DATA_W-1];
            end
            OP_AND: res = a & b;
            OP_OR:  res = a | b;
            OP_XOR: res = a ^ b;
            // The bit just past the kept window is the last one shifted out (0 for a zero shift).
            OP_SHL: begin
                shw = {{DATA_W{1'b0}}, a} << sh;
                res = shw[DATA_W-1:0];
                cy  = shw[DATA_W];
            end
            OP_SHR: begin
                shw = {a, {DATA_W{1'b0}}} >> sh;
                res = shw[2*DATA_W-1:DATA_W];
                cy  = shw[DATA_W-1];
            end
            default: res = '0;
        endcase
        return {res, cy, ov};
    endfunction

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] a_q, b_q;
    logic [2:0]        op_q;
    logic [DATA_W-1:0] res_q, res_d;
    logic              cy_q, cy_d;
    logic              zf_q, zf_d;
    logic              ov_q, ov_d;
    logic              err_q, err_d;
    logic [DATA_W+1:0] eval;
    logic              accept;
    logic              req_err;

    assign accept = i_valid && (state_q == IDLE);

`ifdef ALU_MUL_EN
    localparam logic [CNT_W-1:0] CNT_MUL = CNT_W'(DATA_W - 1);

    logic [2*DATA_W-1:0] acc_q, mcand_q, acc_nx;
    logic [DATA_W-1:0]   mplier_q;

    assign req_err = (opcode == OP_MUL) && single_cycle_mode;
    assign acc_nx  = acc_q + (mplier_q[0] ? mcand_q : '0);

    always_ff @(posedge clk) begin
        if (accept) begin
            acc_q    <= '0;
            mcand_q  <= {{DATA_W{1'b0}}, A};
            mplier_q <= B;
        end else if (state_q == EXEC) begin
            acc_q    <= acc_nx;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
        end
    end
`else
    assign req_err = (opcode == OP_MUL);
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        cy_d    = cy_q;
        zf_d    = zf_q;
        ov_d    = ov_q;
        err_d   = err_q;
        eval    = '0;
        case (state_q)
            IDLE: begin
                if (i_valid) begin
                    if (req_err) begin
                        state_d = DONE;
                        res_d   = '0;
                        cy_d    = 1'b0;
                        zf_d    = 1'b0;
                        ov_d    = 1'b0;
                        err_d   = 1'b1;
                    end else if (single_cycle_mode) begin
                        state_d = DONE;
                        eval    = alu_eval(A, B, opcode);
                        {res_d, cy_d, ov_d} = eval;
                        zf_d    = (eval[DATA_W+1:2] == '0);
                        err_d   = 1'b0;
                    end else begin
                        state_d = EXEC;
`ifdef ALU_MUL_EN
                        cnt_d   = (opcode == OP_MUL) ? CNT_MUL : CNT_ALU;
`else
                        cnt_d   = CNT_ALU;
`endif
                    end
                end
            end
            EXEC: begin
                if (cnt_q == '0) begin
                    state_d = DONE;
`ifdef ALU_MUL_EN
                    if (op_q == OP_MUL) begin
                        eval = {acc_nx[DATA_W-1:0], |acc_nx[2*DATA_W-1:DATA_W],
                                |acc_nx[2*DATA_W-1:DATA_W]};
                    end else begin
                        eval = alu_eval(a_q, b_q, op_q);
                    end
`else
                    eval = alu_eval(a_q, b_q, op_q);
`endif
                    {res_d, cy_d, ov_d} = eval;
                    zf_d  = (eval[DATA_W+1:2] == '0);
                    err_d = 1'b0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            res_q   <= '0;
            cy_q    <= 1'b0;
            zf_q    <= 1'b0;
            ov_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            cy_q    <= cy_d;
            zf_q    <= zf_d;
            ov_q    <= ov_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            a_q  <= A;
            b_q  <= B;
            op_q <= opcode;
        end
    end

    assign o_ready       = (state_q == IDLE);
    assign o_busy        = (state_q == EXEC);
    assign o_valid       = (state_q == DONE);
    assign o_error       = err_q;
    assign result        = res_q;
    assign carry_out     = cy_q;
    assign zero_flag     = zf_q;
    assign overflow_flag = ov_q;
endmodule

// File: tb/tb_alu_core.sv
// Scoreboard bench for alu_core: a driver queues expected responses, a monitor checks them on o_valid.
module tb_alu_core;
`ifdef ALU_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       i_valid = 1'b0;
    logic       o_ready;
    logic [7:0] A = '0;
    logic [7:0] B = '0;
    logic [2:0] opcode = '0;
    logic       single_cycle_mode = 1'b0;
    logic       o_valid, o_busy, o_error;
    logic [7:0] result;
    logic       carry_out, zero_flag, overflow_flag;

    alu_core dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready),
        .A(A), .B(B), .opcode(opcode), .single_cycle_mode(single_cycle_mode),
        .o_valid(o_valid), .o_busy(o_busy), .o_error(o_error), .result(result),
        .carry_out(carry_out), .zero_flag(zero_flag), .overflow_flag(overflow_flag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] res;
        logic       c, z, ov, err;
        int         lat;
        int         acc;
    } exp_t;

    exp_t q[$];
    exp_t me;
    int   checks = 0;
    int   passes = 0;
    int   cyc = 0;
    int   busy_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act === expv) passes++;
        else $display("FAIL %s: got %0h required %0h (t=%0t)", nm, act, expv, $time);
    endtask

    function automatic exp_t mk(input logic [7:0] res, input logic c, input logic z,
                                input logic ov, input logic err, input int lat);
        exp_t e;
        e.res = res; e.c = c; e.z = z; e.ov = ov; e.err = err; e.lat = lat; e.acc = 0;
        return e;
    endfunction

    // Reference model from the arithmetic rules, using plain integers.
    function automatic exp_t model(input int a, input int b, input int op, input bit scm);
        int r, s, sa, sb, n, p;
        bit c, ov;
        r = 0; c = 0; ov = 0;
        if (op == 7 && (scm || !MUL_EN)) return mk(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1);
        sa = (a > 127) ? a - 256 : a;
        sb = (b > 127) ? b - 256 : b;
        n  = b % 8;
        case (op)
            0: begin s = a + b; r = s % 256; c = (s > 255); ov = (sa + sb > 127) || (sa + sb < -128); end
            1: begin r = (a - b + 256) % 256; c = (a < b); ov = (sa - sb > 127) || (sa - sb < -128); end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: begin r = (a << n) % 256; c = (n != 0) && (((a << n) >> 8) % 2 == 1); end
            6: begin r = a >> n; c = (n != 0) && ((a >> (n - 1)) % 2 == 1); end
            default: begin p = a * b; r = p % 256; c = (p > 255); ov = c; end
        endcase
        return mk(8'(r), c, (r == 0), ov, 1'b0, scm ? 1 : ((op == 7) ? 9 : 4));
    endfunction

    task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                         input logic scm, input bit hold, input exp_t e);
        int w;
        w = 0;
        @(negedge clk);
        while (!o_ready && w < 40) begin
            @(negedge clk);
            w++;
        end
        if (!o_ready) begin
            checks++;
            $display("FAIL accept_timeout: o_ready=%0b required 1", o_ready);
        end else begin
            A = a; B = b; opcode = op; single_cycle_mode = scm; i_valid = 1'b1;
            e.acc = cyc + 1;
            q.push_back(e);
            if (!hold) begin
                @(negedge clk);
                i_valid = 1'b0;
            end
        end
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, "_valid"}, 32'(o_valid), 32'd0);
        chk({tag, "_busy"},  32'(o_busy), 32'd0);
        chk({tag, "_error"}, 32'(o_error), 32'd0);
        chk({tag, "_result"}, 32'(result), 32'd0);
        chk({tag, "_flags"}, {29'd0, carry_out, zero_flag, overflow_flag}, 32'd0);
        chk({tag, "_ready"}, 32'(o_ready), 32'd1);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            busy_cnt = 0;
        end else begin
            chk("ready_is_idle", 32'(o_ready), 32'(!o_busy && !o_valid));
            if (o_busy) busy_cnt++;
            if (o_valid) begin
                if (q.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_valid: o_valid=1 with no request pending (t=%0t)", $time);
                end else begin
                    me = q.pop_front();
                    chk("result",   32'(result), 32'(me.res));
                    chk("carry",    32'(carry_out), 32'(me.c));
                    chk("zero",     32'(zero_flag), 32'(me.z));
                    chk("overflow", 32'(overflow_flag), 32'(me.ov));
                    chk("error",    32'(o_error), 32'(me.err));
                    chk("latency",  32'(cyc - me.acc + 1), 32'(me.lat));
                    chk("busy_cycles", 32'(busy_cnt), 32'(me.lat - 1));
                end
                busy_cnt = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] ra, rb;
        logic [2:0] rop;
        logic       rscm;
        bit         rhold;
        int         w;

        #2;
        check_quiet("reset");
        @(negedge clk);
        check_quiet("reset_hold");
        rst = 1'b0;

        issue(8'hFF, 8'h01, 3'b000, 1'b1, 1'b0, mk(8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1));
        issue(8'h80, 8'h01, 3'b001, 1'b0, 1'b0, mk(8'h7F, 1'b0, 1'b0, 1'b1, 1'b0, 4));
        if (MUL_EN)
            issue(8'h10, 8'h11, 3'b111, 1'b0, 1'b0, mk(8'h10, 1'b1, 1'b0, 1'b1, 1'b0, 9));
        else
            issue(8'h10, 8'h11, 3'b111, 1'b0, 1'b0, mk(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1));
        issue(8'h03, 8'h05, 3'b111, 1'b1, 1'b0, mk(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1));
        issue(8'h81, 8'h01, 3'b101, 1'b1, 1'b1, mk(8'h02, 1'b1, 1'b0, 1'b0, 1'b0, 1));
        issue(8'h0F, 8'hF0, 3'b011, 1'b0, 1'b1, mk(8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 4));
        issue(8'h01, 8'h00, 3'b110, 1'b1, 1'b0, mk(8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1));

        for (int i = 0; i < 300; i++) begin
            ra    = 8'($urandom);
            rb    = 8'($urandom);
            rop   = 3'($urandom_range(0, 7));
            rscm  = 1'($urandom_range(0, 1));
            rhold = 1'($urandom_range(0, 1));
            issue(ra, rb, rop, rscm, rhold, model(int'(ra), int'(rb), int'(rop), rscm));
        end
        @(negedge clk);
        i_valid = 1'b0;

        w = 0;
        while (q.size() != 0 && w < 40) begin
            @(negedge clk);
            w++;
        end

        if (MUL_EN)
            issue(8'h37, 8'h5A, 3'b111, 1'b0, 1'b0, mk(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 9));
        else
            issue(8'h37, 8'h5A, 3'b001, 1'b0, 1'b0, mk(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 4));
        @(negedge clk);
        #2;
        rst = 1'b1;
        q.delete();
        #1;
        check_quiet("abort");
        @(negedge clk);
        check_quiet("abort_hold");
        @(posedge clk);
        #2;
        rst = 1'b0;
        issue(8'h7F, 8'h01, 3'b000, 1'b1, 1'b0, mk(8'h80, 1'b0, 1'b0, 1'b1, 1'b0, 1));

        w = 0;
        while (q.size() != 0 && w < 40) begin
            @(negedge clk);
            w++;
        end
        chk("queue_drained", 32'(q.size()), 32'd0);
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/alu_core.md
ALU_CORE -- requirements
Module: alu_core

Interface
REQ-001 The module SHALL have the following ports, each stated as name  direction  width  meaning.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 rst  input  1  reset; asynchronous and active-high.
REQ-004 i_valid  input  1  request valid from the initiator.
REQ-005 o_ready  output  1  core can accept a request; equals (state == IDLE).
REQ-006 A, B  input  8 each  operands.
REQ-007 opcode  input  3  operation: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR, 111 MUL.
REQ-008 single_cycle_mode  input  1  1 = fast path, 0 = multi-cycle path.
REQ-009 o_valid  output  1  one-cycle pulse marking a completed response.
REQ-010 o_busy  output  1  high while state == EXEC.
REQ-011 o_error  output  1  response is illegal; qualified by o_valid.
REQ-012 result  output  8  operation result.
REQ-013 carry_out, zero_flag, overflow_flag  output  1 each  status flags for result.

Function
REQ-014 An accept SHALL occur on a rising edge where i_valid && o_ready; A, B, opcode and single_cycle_mode SHALL be captured at that edge (E0), and inputs SHALL be ignored while o_ready = 0.
REQ-015 The state machine SHALL use the states IDLE, EXEC and DONE, with the following transitions:
  - IDLE -> DONE on an accept in single-cycle mode, or on an accept of an error request.
  - IDLE -> EXEC on any other accept.
  - EXEC -> DONE when the iteration counter reaches 0.
  - DONE -> IDLE always.
REQ-016 o_valid SHALL be 1 only in DONE, and result, flags and o_error SHALL update on the edge that enters DONE.
REQ-017 Latency from E0 to the o_valid high cycle SHALL be:
  - 1 cycle for the single-cycle path and for errors.
  - 4 cycles for multi-cycle non-MUL operations (counter loaded with 2).
  - 9 cycles for MUL (8 shift-add iterations, counter loaded with 7).
REQ-018 result, flags and o_error SHALL hold their values until the next entry into DONE.
REQ-019 ADD: result = (A+B)[7:0]; carry_out = bit 8; overflow_flag = signed two's-complement overflow.
REQ-020 SUB: result = (A-B)[7:0]; carry_out = 1 when A < B unsigned (borrow); overflow_flag = signed overflow.
REQ-021 AND/OR/XOR: bitwise result; carry_out = 0; overflow_flag = 0.
REQ-022 SHL/SHR:
  - Logical shift of A by B[2:0].
  - carry_out = last bit shifted out; 0 when B[2:0] = 0.
  - overflow_flag = 0.
REQ-023 MUL:
  - Unsigned iterative shift-add producing a 16-bit product.
  - result = product[7:0].
  - carry_out = overflow_flag = |product[15:8].
REQ-024 zero_flag SHALL equal (result == 8'h00) for every non-error response.
REQ-025 An error request SHALL be MUL with single_cycle_mode = 1, or opcode 111 when MUL is compiled out; its response SHALL be o_error = 1, result = 0 and all flags 0, including zero_flag.
REQ-026 A non-error response SHALL have o_error = 0.
REQ-027 Throughput SHALL be at most one request per 2 cycles, because o_ready is low in DONE.

Reset
REQ-028 While rst = 1, state SHALL be IDLE, and o_valid, o_busy, o_error, result, carry_out, zero_flag and overflow_flag SHALL all be 0.
REQ-029 While rst = 1, o_ready SHALL be 1.
REQ-030 Reset asserted in EXEC or DONE SHALL abort the operation immediately with no o_valid, and the first edge after release SHALL be able to accept a request.

Configuration
REQ-031 When ALU_MUL_EN is defined, opcode 111 SHALL perform the iterative MUL described in REQ-023.
REQ-032 When ALU_MUL_EN is undefined, the multiplier datapath SHALL be absent and opcode 111 SHALL always be an error request with 1-cycle latency.

Verification
REQ-033 The bench SHALL cover ADD, single_cycle_mode = 1, A = 8'hFF, B = 8'h01 -> o_valid 1 cycle after accept, result 8'h00, carry_out 1, zero_flag 1, overflow_flag 0.
REQ-034 The bench SHALL cover SUB, single_cycle_mode = 0, A = 8'h80, B = 8'h01 -> o_busy high for 3 cycles, o_valid 4 cycles after accept, result 8'h7F, carry_out 0, overflow_flag 1.
REQ-035 The bench SHALL cover MUL with ALU_MUL_EN, single_cycle_mode = 0, A = 8'h10, B = 8'h11 -> o_valid 9 cycles after accept, result 8'h10, carry_out = overflow_flag = 1; o_ready stays low throughout.
REQ-036 The bench SHALL cover MUL with single_cycle_mode = 1, and also without ALU_MUL_EN -> o_error 1, result 0, all flags 0, 1-cycle latency.
REQ-037 The bench SHALL cover SHL, A = 8'h81, B = 8'h01 -> result 8'h02, carry_out 1; and i_valid held high in DONE -> no accept until IDLE.
REQ-038 The bench SHALL cover rst pulsed during MUL EXEC -> no o_valid, all outputs 0, and a new ADD accepted on the first edge after release.
